// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared FSM encoding and saturation bounds for the psum accumulator
package psum_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bounds of a w-bit two's complement word, valid for w up to 63
  function automatic longint sat_hi(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// rtl/psum_sat_add.sv - signed W-bit adder clamped to the representable range
module psum_sat_add #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  import psum_pkg::*;

  localparam logic signed [W:0] HI = (W+1)'(sat_hi(W));
  localparam logic signed [W:0] LO = (W+1)'(sat_lo(W));

  logic signed [W:0] sum;

  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum > HI)
      y = HI[W-1:0];
    else if (sum < LO)
      y = LO[W-1:0];
    else
      y = sum[W-1:0];
  end

endmodule

// File: rtl/psum_acc_ctrl.sv
// rtl/psum_acc_ctrl.sv - two-stage read-modify-write psum accumulator with paired-word drain
module psum_acc_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [ADDR_WIDTH-1:0]        i_in_addr,
  input  logic signed [DATA_WIDTH-1:0] i_in_data0,
  input  logic signed [DATA_WIDTH-1:0] i_in_data1,
  input  logic                         i_in_first,
  input  logic                         i_drain_start,
  input  logic [ADDR_WIDTH-1:0]        i_drain_base,
  input  logic [ADDR_WIDTH-1:0]        i_drain_len,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [DATA_WIDTH-1:0]        o_out_data0,
  output logic [DATA_WIDTH-1:0]        o_out_data1,
  output logic                         o_busy,
  output logic                         o_drain_done,
  output logic                         o_wr_en,
  output logic [ADDR_WIDTH-1:0]        o_wr_addr0,
  output logic [ADDR_WIDTH-1:0]        o_wr_addr1,
  output logic [DATA_WIDTH-1:0]        o_wr_data0,
  output logic [DATA_WIDTH-1:0]        o_wr_data1,
  output logic                         o_rd_en,
  output logic [ADDR_WIDTH-1:0]        o_rd_addr0,
  output logic [ADDR_WIDTH-1:0]        o_rd_addr1,
  input  logic [DATA_WIDTH-1:0]        i_rd_data0,
  input  logic [DATA_WIDTH-1:0]        i_rd_data1
);
  import psum_pkg::*;

  logic [1:0]                  state;
  logic                        ready_en;
  logic                        s1_valid, s1_first;
  logic [ADDR_WIDTH-1:0]       s1_addr0, s1_addr1;
  logic signed [DATA_WIDTH-1:0] s1_data0, s1_data1;
  logic                        s2_valid;
  logic [ADDR_WIDTH-1:0]       s2_addr0, s2_addr1;
  logic signed [DATA_WIDTH-1:0] s2_data0, s2_data1;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data0, out_data1;
  logic [ADDR_WIDTH-1:0]       ptr, cnt;

  logic                        accept, pipe_empty, drain_go, out_fire, drain_rd;
  logic signed [DATA_WIDTH-1:0] stored0, stored1, sum0, sum1, res0, res1;

  // ready_en keeps o_in_ready low through reset and the first cycle after release
  assign o_in_ready = ready_en & ((state == ST_IDLE) | (state == ST_ACC));
  assign accept     = i_in_valid & o_in_ready;
  assign pipe_empty = ~s1_valid & ~s2_valid;
  assign drain_go   = (state == ST_IDLE) & pipe_empty & i_drain_start & ~accept;
  assign out_fire   = out_valid & i_out_ready;
  assign drain_rd   = (state == ST_DRAIN) & (cnt != '0) & (~out_valid | i_out_ready);

  // The S2 word is committed only at the end of this cycle, so S1 must see it here
  always_comb begin
    stored0 = i_rd_data0;
    stored1 = i_rd_data1;
    if (s2_valid && s1_addr0 == s2_addr0)      stored0 = s2_data0;
    else if (s2_valid && s1_addr0 == s2_addr1) stored0 = s2_data1;
    if (s2_valid && s1_addr1 == s2_addr0)      stored1 = s2_data0;
    else if (s2_valid && s1_addr1 == s2_addr1) stored1 = s2_data1;
  end

  psum_sat_add #(.W(DATA_WIDTH)) u_add0 (.a(s1_data0), .b(stored0), .y(sum0));
  psum_sat_add #(.W(DATA_WIDTH)) u_add1 (.a(s1_data1), .b(stored1), .y(sum1));

  assign res0 = s1_first ? s1_data0 : sum0;
  assign res1 = s1_first ? s1_data1 : sum1;

  always_comb begin
    o_wr_en    = s2_valid;
    o_wr_addr0 = '0;
    o_wr_addr1 = '0;
    o_wr_data0 = '0;
    o_wr_data1 = '0;
    if (s2_valid) begin
      o_wr_addr0 = s2_addr0;
      o_wr_addr1 = s2_addr1;
      o_wr_data0 = s2_data0;
      o_wr_data1 = s2_data1;
    end
    o_rd_en    = s1_valid | drain_rd;
    o_rd_addr0 = '0;
    o_rd_addr1 = '0;
    if (s1_valid) begin
      o_rd_addr0 = s1_addr0;
      o_rd_addr1 = s1_addr1;
    end else if (drain_rd) begin
      o_rd_addr0 = ptr;
      o_rd_addr1 = ptr + ADDR_WIDTH'(1);
    end
  end

  assign o_out_valid  = out_valid;
  assign o_out_data0  = out_data0;
  assign o_out_data1  = out_data1;
  assign o_drain_done = (state == ST_DONE);
  assign o_busy       = (state != ST_IDLE) | s1_valid | s2_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      ready_en  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_addr0  <= '0;
      s1_addr1  <= '0;
      s1_data0  <= '0;
      s1_data1  <= '0;
      s2_valid  <= 1'b0;
      s2_addr0  <= '0;
      s2_addr1  <= '0;
      s2_data0  <= '0;
      s2_data1  <= '0;
      out_valid <= 1'b0;
      out_data0 <= '0;
      out_data1 <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_first <= i_in_first;
        s1_addr0 <= i_in_addr;
        s1_addr1 <= i_in_addr + ADDR_WIDTH'(1);
        s1_data0 <= i_in_data0;
        s1_data1 <= i_in_data1;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr0 <= s1_addr0;
        s2_addr1 <= s1_addr1;
        s2_data0 <= res0;
        s2_data1 <= res1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_ACC;
          end else if (drain_go) begin
            ptr   <= i_drain_base;
            cnt   <= i_drain_len;
            state <= (i_drain_len == '0) ? ST_DONE : ST_DRAIN;
          end
        end
        ST_ACC: begin
          if (!accept && pipe_empty) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (drain_rd) begin
            out_valid <= 1'b1;
            out_data0 <= i_rd_data0;
            out_data1 <= i_rd_data1;
            ptr       <= ptr + ADDR_WIDTH'(2);
            cnt       <= cnt - ADDR_WIDTH'(1);
          end else if (out_fire) begin
            out_valid <= 1'b0;
            if (cnt == '0) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// tb/tb_psum_acc_ctrl.sv - self-checking bench for psum_acc_ctrl with a behavioural psum memory
module tb_psum_acc_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_in_valid, o_in_ready, i_in_first;
  logic [7:0] i_in_addr, i_in_data0, i_in_data1;
  logic       i_drain_start;
  logic [7:0] i_drain_base, i_drain_len;
  logic       o_out_valid, i_out_ready;
  logic [7:0] o_out_data0, o_out_data1;
  logic       o_busy, o_drain_done;
  logic       o_wr_en, o_rd_en;
  logic [7:0] o_wr_addr0, o_wr_addr1, o_wr_data0, o_wr_data1;
  logic [7:0] o_rd_addr0, o_rd_addr1, i_rd_data0, i_rd_data1;

  logic [7:0] mem [0:255];

  psum_acc_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_addr(i_in_addr), .i_in_data0(i_in_data0), .i_in_data1(i_in_data1), .i_in_first(i_in_first),
    .i_drain_start(i_drain_start), .i_drain_base(i_drain_base), .i_drain_len(i_drain_len),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data0(o_out_data0), .o_out_data1(o_out_data1),
    .o_busy(o_busy), .o_drain_done(o_drain_done),
    .o_wr_en(o_wr_en), .o_wr_addr0(o_wr_addr0), .o_wr_addr1(o_wr_addr1),
    .o_wr_data0(o_wr_data0), .o_wr_data1(o_wr_data1),
    .o_rd_en(o_rd_en), .o_rd_addr0(o_rd_addr0), .o_rd_addr1(o_rd_addr1),
    .i_rd_data0(i_rd_data0), .i_rd_data1(i_rd_data1)
  );

  always #5 i_clk = ~i_clk;

  assign i_rd_data0 = mem[o_rd_addr0];
  assign i_rd_data1 = mem[o_rd_addr1];

  always @(posedge i_clk) begin
    if (o_wr_en) begin
      mem[o_wr_addr0] <= o_wr_data0;
      mem[o_wr_addr1] <= o_wr_data1;
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0, d1;
    logic       first;
    logic [7:0] ea0, ea1;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] wr_q [$];
  logic [15:0] dr_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  bit          seen_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_wr_en) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got %h expected no write",
                   {o_wr_addr0, o_wr_addr1, o_wr_data0, o_wr_data1});
        end else begin
          chk("write", {o_wr_addr0, o_wr_addr1, o_wr_data0, o_wr_data1}, wr_q.pop_front());
        end
      end
      if (o_out_valid) seen_valid = 1;
      if (o_out_valid && i_out_ready) begin
        if (dr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_drain_beat: got %h expected none", {o_out_data0, o_out_data1});
        end else begin
          chk("drain_beat", {16'h0, o_out_data0, o_out_data1}, {16'h0, dr_q.pop_front()});
        end
      end
      if (o_drain_done) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] snap;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // base, pair, first, expected write addrs and data (hand-derived)
    vecs[0] = '{8'd4,   8'd5,   8'hFD, 1'b1, 8'd4,   8'd5, 8'd5,   8'hFD};
    vecs[1] = '{8'd4,   8'd2,   8'd2,  1'b0, 8'd4,   8'd5, 8'd7,   8'hFF};
    vecs[2] = '{8'd10,  8'd120, 8'h88, 1'b1, 8'd10,  8'd11, 8'd120, 8'h88};
    vecs[3] = '{8'd10,  8'd20,  8'hEC, 1'b0, 8'd10,  8'd11, 8'h7F,  8'h80};
    vecs[4] = '{8'd255, 8'd1,   8'd2,  1'b1, 8'd255, 8'd0, 8'd1,   8'd2};
    vecs[5] = '{8'd6,   8'd10,  8'd11, 1'b1, 8'd6,   8'd7, 8'd10,  8'd11};
    vecs[6] = '{8'd7,   8'd5,   8'd3,  1'b0, 8'd7,   8'd8, 8'd16,  8'd3};
    vecs[7] = '{8'd0,   8'hFF,  8'hFF, 1'b0, 8'd0,   8'd1, 8'd1,   8'hFF};
    vecs[8] = '{8'd5,   8'd4,   8'hEC, 1'b0, 8'd5,   8'd6, 8'd3,   8'hF6};

    i_rst_n = 0; i_in_valid = 0; i_in_addr = 0; i_in_data0 = 0; i_in_data1 = 0; i_in_first = 0;
    i_drain_start = 0; i_drain_base = 0; i_drain_len = 0; i_out_ready = 0;
    #3;
    chk("reset_outputs", {o_in_ready, o_busy, o_wr_en, o_rd_en, o_out_valid, o_drain_done,
                          o_wr_addr0, o_rd_addr0, o_out_data0}, 32'h0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    chk("ready_low_after_release", {31'h0, o_in_ready}, 32'h0);
    @(posedge i_clk); #1;
    chk("ready_high_next_cycle", {31'h0, o_in_ready}, 32'h1);

    for (int i = 0; i < 9; i++) begin
      i_in_valid = 1;
      i_in_addr  = vecs[i].addr;
      i_in_data0 = vecs[i].d0;
      i_in_data1 = vecs[i].d1;
      i_in_first = vecs[i].first;
      wr_q.push_back({vecs[i].ea0, vecs[i].ea1, vecs[i].e0, vecs[i].e1});
      @(posedge i_clk); #1;
    end
    i_in_valid = 0;
    repeat (4) @(posedge i_clk);
    #1;
    chk("writes_all_seen", wr_q.size(), 0);
    chk("idle_mem_outputs", {o_busy, o_rd_en, o_wr_en, o_rd_addr0, o_rd_addr1, o_wr_addr0}, 32'h0);

    // Drain base 4 len 2 with a 3-cycle consumer stall
    done_cnt = 0;
    dr_q.push_back({8'd7, 8'd3});
    dr_q.push_back({8'hF6, 8'd16});
    i_drain_start = 1; i_drain_base = 8'd4; i_drain_len = 8'd2;
    @(posedge i_clk); #1;
    i_drain_start = 0;
    for (int i = 0; i < 10 && !o_out_valid; i++) begin
      @(posedge i_clk); #1;
    end
    chk("drain_first_valid", {31'h0, o_out_valid}, 32'h1);
    snap = {o_out_data0, o_out_data1};
    chk("drain_first_data", {16'h0, snap}, {16'h0, 8'd7, 8'd3});
    repeat (3) begin
      @(negedge i_clk);
      chk("stall_stable", {15'h0, o_out_valid, o_out_data0, o_out_data1}, {15'h0, 1'b1, snap});
    end
    @(posedge i_clk); #1;
    i_out_ready = 1;
    for (int i = 0; i < 20 && done_cnt == 0; i++) begin
      @(posedge i_clk); #1;
    end
    repeat (3) @(posedge i_clk);
    #1;
    i_out_ready = 0;
    chk("drain_done_pulses", done_cnt, 1);
    chk("drain_beats_all_seen", dr_q.size(), 0);

    // Zero-length drain goes straight to DONE
    seen_valid = 0;
    done_cnt = 0;
    i_drain_start = 1; i_drain_base = 8'd9; i_drain_len = 8'd0;
    @(posedge i_clk); #1;
    i_drain_start = 0;
    chk("len0_done_next_cycle", {31'h0, o_drain_done}, 32'h1);
    @(posedge i_clk); #1;
    chk("len0_done_single", {30'h0, o_drain_done, o_busy}, 32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("len0_done_count", done_cnt, 1);
    chk("len0_no_valid", {31'h0, seen_valid}, 32'h0);

    // Drain request while accumulating is ignored
    done_cnt = 0;
    i_in_valid = 1; i_in_addr = 8'd40; i_in_data0 = 8'd1; i_in_data1 = 8'd1; i_in_first = 1;
    wr_q.push_back({8'd40, 8'd41, 8'd1, 8'd1});
    @(posedge i_clk); #1;
    i_in_valid = 0;
    i_drain_start = 1; i_drain_base = 8'd0; i_drain_len = 8'd3;
    chk("busy_in_acc", {31'h0, o_busy}, 32'h1);
    @(posedge i_clk); #1;
    i_drain_start = 0;
    repeat (10) @(posedge i_clk);
    #1;
    chk("acc_drain_ignored_done", done_cnt, 0);
    chk("acc_drain_ignored_valid", {31'h0, seen_valid}, 32'h0);
    chk("acc_write_seen", wr_q.size(), 0);

    // Reset while S2 holds a beat
    i_in_valid = 1; i_in_addr = 8'd20; i_in_data0 = 8'd9; i_in_data1 = 8'd9; i_in_first = 1;
    @(posedge i_clk); #1;
    i_in_valid = 0;
    @(posedge i_clk); #1;
    chk("s2_before_reset", {15'h0, o_wr_en, o_wr_addr0, o_wr_data0}, {15'h0, 1'b1, 8'd20, 8'd9});
    #1 i_rst_n = 0;
    #1;
    chk("reset_mid_outputs", {o_in_ready, o_busy, o_wr_en, o_rd_en, o_out_valid, o_drain_done,
                              o_wr_addr0, o_wr_data0, o_rd_addr0}, 32'h0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    chk("mem_unchanged_after_reset", {16'h0, mem[20], mem[21]}, 32'h0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("no_write_after_reset", {31'h0, o_wr_en}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
